// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared encodings and sizes for the breakout game blocks
package breakout_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WIN  = 2'b10,
        S_END  = 2'b11
    } game_state_t;

    typedef enum logic [1:0] {
        S_RUN     = 2'b00,
        S_RESPAWN = 2'b01,
        S_DONE    = 2'b10
    } ball_state_t;

    localparam int NUM_BRICKS     = 32;
    localparam int BRICK_IDX_W    = 5;
    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_NUM_DIGITS = 4;
    localparam int SCORE_W        = BCD_DIGIT_W * BCD_NUM_DIGITS;

endpackage

// File: rtl/breakout_ball_ctrl_if.sv
// rtl/breakout_ball_ctrl_if.sv - event inputs and game status outputs of the ball controller
interface breakout_ball_ctrl_if;
    import breakout_pkg::*;

    logic [1:0]             game_state;
    logic                   game_reset;
    logic                   brick_hit;
    logic [BRICK_IDX_W-1:0] brick_idx;
    logic                   ball_miss;
    logic [NUM_BRICKS-1:0]  brick_map;
    logic [1:0]             lives;
    logic [SCORE_W-1:0]     score;
    logic                   respawn_busy;
    logic                   win_sig;
    logic                   lose_sig;

    modport master (
        output game_state, game_reset, brick_hit, brick_idx, ball_miss,
        input  brick_map, lives, score, respawn_busy, win_sig, lose_sig
    );

    modport slave (
        input  game_state, game_reset, brick_hit, brick_idx, ball_miss,
        output brick_map, lives, score, respawn_busy, win_sig, lose_sig
    );

endinterface

// File: rtl/breakout_bcd_add.sv
// rtl/breakout_bcd_add.sv - 4-digit BCD plus 1-digit addend, saturating at 9999
module breakout_bcd_add
    import breakout_pkg::*;
(
    input  logic [SCORE_W-1:0]     a_i,
    input  logic [BCD_DIGIT_W-1:0] b_i,
    output logic [SCORE_W-1:0]     sum_o
);

    logic [BCD_DIGIT_W:0]   digit;
    logic                   carry;
    logic [SCORE_W-1:0]     raw;

    // Ripple the addend through the digits; a carry out of the top digit saturates.
    always_comb begin
        digit = '0;
        carry = 1'b0;
        raw   = '0;
        for (int i = 0; i < BCD_NUM_DIGITS; i++) begin
            digit = {1'b0, a_i[i*BCD_DIGIT_W +: BCD_DIGIT_W]} + {{BCD_DIGIT_W{1'b0}}, carry};
            if (i == 0) begin
                digit = digit + {1'b0, b_i};
            end
            if (digit > (BCD_DIGIT_W+1)'(9)) begin
                digit = digit - (BCD_DIGIT_W+1)'(10);
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            raw[i*BCD_DIGIT_W +: BCD_DIGIT_W] = digit[BCD_DIGIT_W-1:0];
        end
        sum_o = carry ? {BCD_NUM_DIGITS{BCD_DIGIT_W'(9)}} : raw;
    end

endmodule

// File: rtl/breakout_ball_ctrl.sv
// rtl/breakout_ball_ctrl.sv - brick wall, lives, score and respawn tracking feeding the game FSM
module breakout_ball_ctrl #(
    parameter int INIT_LIVES  = 3,
    parameter int POINTS      = 5,
    parameter int RESPAWN_CYC = 25000000
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    breakout_ball_ctrl_if.slave  bus
);
    import breakout_pkg::*;

    localparam int              CNT_W     = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESPAWN_CYC - 1);

    ball_state_t            state_q, state_d;
    logic [NUM_BRICKS-1:0]  brick_map_q, brick_map_d;
    logic [1:0]             lives_q, lives_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [5:0]             bricks_left_q, bricks_left_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   win_q, win_d;
    logic                   lose_q, lose_d;
    logic [SCORE_W-1:0]     score_sum;
    logic                   hit_ok;
    logic                   last_hit;

    breakout_bcd_add u_bcd_add (
        .a_i   (score_q),
        .b_i   (BCD_DIGIT_W'(POINTS)),
        .sum_o (score_sum)
    );

    // State register; game_reset reloads everything and overrides any event that cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || bus.game_reset) begin
            state_q       <= S_RUN;
            brick_map_q   <= '1;
            lives_q       <= 2'(INIT_LIVES);
            score_q       <= '0;
            bricks_left_q <= 6'(NUM_BRICKS);
            cnt_q         <= '0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            brick_map_q   <= brick_map_d;
            lives_q       <= lives_d;
            score_q       <= score_d;
            bricks_left_q <= bricks_left_d;
            cnt_q         <= cnt_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    // Next state: hit is resolved before miss, and a winning hit swallows a coincident miss.
    always_comb begin
        state_d       = state_q;
        brick_map_d   = brick_map_q;
        lives_d       = lives_q;
        score_d       = score_q;
        bricks_left_d = bricks_left_q;
        cnt_d         = cnt_q;
        win_d         = 1'b0;
        lose_d        = 1'b0;
        last_hit      = 1'b0;
        hit_ok        = bus.brick_hit && (32'(bus.brick_idx) < NUM_BRICKS)
                        && brick_map_q[bus.brick_idx];

        if (bus.game_state == S_PLAY) begin
            case (state_q)
                S_RUN: begin
                    if (hit_ok) begin
                        brick_map_d[bus.brick_idx] = 1'b0;
                        score_d       = score_sum;
                        bricks_left_d = bricks_left_q - 6'd1;
                        if (bricks_left_q == 6'd1) begin
                            win_d    = 1'b1;
                            state_d  = S_DONE;
                            last_hit = 1'b1;
                        end
                    end
                    if (bus.ball_miss && !last_hit) begin
                        lives_d = lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            lose_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            state_d = S_RESPAWN;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                S_RESPAWN: begin
                    if (cnt_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.brick_map    = brick_map_q;
    assign bus.lives        = lives_q;
    assign bus.score        = score_q;
    assign bus.respawn_busy = (state_q == S_RESPAWN);
    assign bus.win_sig      = win_q;
    assign bus.lose_sig     = lose_q;

endmodule

// File: tb/tb_breakout_ball_ctrl.sv
// tb/tb_breakout_ball_ctrl.sv - directed-vector bench for breakout_ball_ctrl
module tb_breakout_ball_ctrl;
    import breakout_pkg::*;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   busy_n;

    logic [15:0] add_a;
    logic [3:0]  add_b;
    logic [15:0] add_s;

    breakout_ball_ctrl_if bus();

    breakout_ball_ctrl #(
        .INIT_LIVES  (3),
        .POINTS      (5),
        .RESPAWN_CYC (8)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    breakout_bcd_add u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_s)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic ev(input logic h, input logic [4:0] idx, input logic m);
        bus.brick_hit = h;
        bus.brick_idx = idx;
        bus.ball_miss = m;
        step();
        bus.brick_hit = 1'b0;
        bus.ball_miss = 1'b0;
    endtask

    // counts cycles with respawn_busy high; optional idle window and a hit at cycle 2
    task automatic wait_respawn(input int pause_at, input int pause_len, input logic hit_at2,
                                output int n);
        n = 0;
        while (bus.respawn_busy && n < 100) begin
            n++;
            if (pause_at > 0 && n == pause_at) bus.game_state = S_IDLE;
            if (pause_at > 0 && n == pause_at + pause_len) bus.game_state = S_PLAY;
            if (hit_at2 && n == 2) begin
                bus.brick_hit = 1'b1;
                bus.brick_idx = 5'd3;
            end
            step();
            bus.brick_hit = 1'b0;
        end
        bus.game_state = S_PLAY;
    endtask

    task automatic game_rst();
        bus.game_reset = 1'b1;
        step();
        bus.game_reset = 1'b0;
    endtask

    initial begin
        bus.game_state = S_IDLE;
        bus.game_reset = 1'b0;
        bus.brick_hit  = 1'b0;
        bus.brick_idx  = '0;
        bus.ball_miss  = 1'b0;
        add_a = '0;
        add_b = '0;

        step();
        step();
        sys_rst = 1'b0;
        bus.game_state = S_PLAY;
        game_rst();
        chk_vec("rst_map",   bus.brick_map, 32'hFFFF_FFFF);
        chk_vec("rst_lives", 32'(bus.lives), 32'd3);
        chk_vec("rst_score", 32'(bus.score), 32'h0);
        chk_vec("rst_win",   32'(bus.win_sig), 32'd0);
        chk_vec("rst_lose",  32'(bus.lose_sig), 32'd0);
        chk_vec("rst_busy",  32'(bus.respawn_busy), 32'd0);

        ev(1'b1, 5'd7, 1'b0);
        chk_vec("hit7_map",   bus.brick_map, 32'hFFFF_FF7F);
        chk_vec("hit7_score", 32'(bus.score), 32'h0005);
        ev(1'b1, 5'd7, 1'b0);
        chk_vec("rehit7_map",   bus.brick_map, 32'hFFFF_FF7F);
        chk_vec("rehit7_score", 32'(bus.score), 32'h0005);
        bus.game_state = S_IDLE;
        ev(1'b1, 5'd8, 1'b0);
        bus.game_state = S_PLAY;
        chk_vec("idle_hit_map", bus.brick_map, 32'hFFFF_FF7F);

        ev(1'b0, 5'd0, 1'b1);
        chk_vec("miss1_lives", 32'(bus.lives), 32'd2);
        chk_vec("miss1_busy",  32'(bus.respawn_busy), 32'd1);
        wait_respawn(0, 0, 1'b1, busy_n);
        chk_vec("busy_len8",     32'(busy_n), 32'd8);
        chk_vec("busy_hit3_map", bus.brick_map, 32'hFFFF_FF7F);

        ev(1'b0, 5'd0, 1'b1);
        chk_vec("miss2_lives", 32'(bus.lives), 32'd1);
        wait_respawn(3, 5, 1'b0, busy_n);
        chk_vec("busy_len13", 32'(busy_n), 32'd13);

        ev(1'b0, 5'd0, 1'b1);
        chk_vec("miss3_lives", 32'(bus.lives), 32'd0);
        chk_vec("miss3_lose",  32'(bus.lose_sig), 32'd1);
        chk_vec("miss3_busy",  32'(bus.respawn_busy), 32'd0);
        step();
        chk_vec("lose_pulse_end", 32'(bus.lose_sig), 32'd0);
        ev(1'b1, 5'd0, 1'b1);
        chk_vec("done_map",   bus.brick_map, 32'hFFFF_FF7F);
        chk_vec("done_lives", 32'(bus.lives), 32'd0);
        chk_vec("done_lose",  32'(bus.lose_sig), 32'd0);
        chk_vec("done_win",   32'(bus.win_sig), 32'd0);
        game_rst();
        chk_vec("grst_lives", 32'(bus.lives), 32'd3);
        chk_vec("grst_map",   bus.brick_map, 32'hFFFF_FFFF);
        chk_vec("grst_score", 32'(bus.score), 32'h0);

        for (int i = 0; i < 31; i++) ev(1'b1, 5'(i), 1'b0);
        chk_vec("hit31_win", 32'(bus.win_sig), 32'd0);
        ev(1'b1, 5'd31, 1'b0);
        chk_vec("hit32_win",   32'(bus.win_sig), 32'd1);
        chk_vec("hit32_score", 32'(bus.score), 32'h0160);
        chk_vec("hit32_map",   bus.brick_map, 32'h0);
        step();
        chk_vec("win_pulse_end", 32'(bus.win_sig), 32'd0);

        game_rst();
        ev(1'b1, 5'd0, 1'b1);
        chk_vec("both_map",   bus.brick_map, 32'hFFFF_FFFE);
        chk_vec("both_lives", 32'(bus.lives), 32'd2);
        chk_vec("both_score", 32'(bus.score), 32'h0005);
        wait_respawn(0, 0, 1'b0, busy_n);
        chk_vec("both_busy_len", 32'(busy_n), 32'd8);
        for (int i = 1; i < 31; i++) ev(1'b1, 5'(i), 1'b0);
        ev(1'b1, 5'd31, 1'b1);
        chk_vec("winmiss_win",   32'(bus.win_sig), 32'd1);
        chk_vec("winmiss_lose",  32'(bus.lose_sig), 32'd0);
        chk_vec("winmiss_lives", 32'(bus.lives), 32'd2);
        chk_vec("winmiss_score", 32'(bus.score), 32'h0160);
        step();
        chk_vec("winmiss_end", 32'(bus.win_sig), 32'd0);

        game_rst();
        ev(1'b1, 5'd4, 1'b0);
        bus.game_reset = 1'b1;
        ev(1'b1, 5'd5, 1'b0);
        bus.game_reset = 1'b0;
        chk_vec("grst_hit_map",   bus.brick_map, 32'hFFFF_FFFF);
        chk_vec("grst_hit_score", 32'(bus.score), 32'h0);

        add_a = 16'h0155; add_b = 4'd5; #1; chk_vec("bcd_0155_5", 32'(add_s), 32'h0160);
        add_a = 16'h0999; add_b = 4'd5; #1; chk_vec("bcd_0999_5", 32'(add_s), 32'h1004);
        add_a = 16'h0009; add_b = 4'd9; #1; chk_vec("bcd_0009_9", 32'(add_s), 32'h0018);
        add_a = 16'h1234; add_b = 4'd9; #1; chk_vec("bcd_1234_9", 32'(add_s), 32'h1243);
        add_a = 16'h9995; add_b = 4'd5; #1; chk_vec("bcd_sat_9995_5", 32'(add_s), 32'h9999);
        add_a = 16'h9990; add_b = 4'd9; #1; chk_vec("bcd_sat_9990_9", 32'(add_s), 32'h9999);
        add_a = 16'h9999; add_b = 4'd9; #1; chk_vec("bcd_sat_9999_9", 32'(add_s), 32'h9999);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
